mmio_periph_resp: RTL

//  Memory-mapped responder on the CPU data bus (addr/re/we/wdata/rdata), serving accesses at or

---
 rtl/mmio_periph_resp.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mmio_periph_resp.sv
// Memory-mapped peripheral responder: LED register, synchronized switches and
// an 8N1 UART transmitter fed from a small TX FIFO with status/control.
module mmio_periph_resp #(
  parameter int          BAUD_DIV   = 434,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] LED_ADDR   = 32'h0000_C000,
  parameter logic [31:0] SW_ADDR    = 32'h0000_C001,
  parameter logic [31:0] TX_ADDR    = 32'h0000_C004,
  parameter logic [31:0] STAT_ADDR  = 32'h0000_C005
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [9:0]  sw,
  output logic [9:0]  led,
  output logic        tx
);

  localparam int            BW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int            PW        = $clog2(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [3:0]    DEPTH_CNT = 4'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [9:0]    led_q, led_d;
  logic [9:0]    sw_meta_q, sw_meta_d;
  logic [9:0]    sw_sync_q, sw_sync_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];

  logic sel_led, sel_sw, sel_tx, sel_stat;
  logic full, empty, busy, push, pop, bit_end;
  logic unused_wdata;

  assign sel_led  = (addr == LED_ADDR);
  assign sel_sw   = (addr == SW_ADDR);
  assign sel_tx   = (addr == TX_ADDR);
  assign sel_stat = (addr == STAT_ADDR);

  assign full    = (count_q == DEPTH_CNT);
  assign empty   = (count_q == 4'd0);
  assign busy    = (state_q != S_IDLE) | ~empty;
  assign push    = we & sel_tx & ~full;
  assign pop     = (state_q == S_IDLE) & ~empty;
  assign bit_end = (bcnt_q == BAUD_LAST);

  assign unused_wdata = ^wdata[31:10];

  // tx_d is the line level for the state being entered, so tx stays a pure flop output
  always_comb begin
    state_d   = state_q;
    bcnt_d    = bcnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          shift_d = fifo_mem_q[rd_ptr_q];
          bcnt_d  = '0;
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bcnt_d    = '0;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          state_d   = S_DATA;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bcnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          bcnt_d  = '0;
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // A full FIFO rejects the push even if the transmitter pops in the same cycle
  always_comb begin
    led_d     = led_q;
    sw_meta_d = sw;
    sw_sync_d = sw_meta_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    if (we && sel_led) led_d = wdata[9:0];
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
    if (we && sel_stat && wdata[0]) ovf_d = 1'b0;
    if (we && sel_tx && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bcnt_q    <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      led_q     <= 10'd0;
      sw_meta_q <= 10'd0;
      sw_sync_q <= 10'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= 4'd0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      led_q     <= led_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= wdata[7:0];
  end

  always_comb begin
    rdata = 32'h0000_DEAD;
    if (re) begin
      if (sel_sw) rdata = {22'b0, sw_sync_q};
      else if (sel_led) rdata = {22'b0, led_q};
      else if (sel_stat) rdata = {24'b0, count_q, ovf_q, full, empty, busy};
    end
  end

  assign led = led_q;
  assign tx  = tx_q;

endmodule
